// File: rtl/cursor_overlay_pipe.sv
// Arrow-cursor overlay on a VGA pixel stream: frame-shadowed, clamped position,
// border/fill shape, optional blink, forced blanking, fixed 2-cycle latency.
module cursor_overlay_pipe #(
    parameter int unsigned CW           = 12,
    parameter int unsigned CUR_W        = 16,
    parameter int unsigned CUR_H        = 16,
    parameter logic [11:0] CUR_RGB      = 12'hFFF,
    parameter logic [11:0] BORDER_RGB   = 12'h000,
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned BLINK_FRAMES = 0
) (
    input  logic          pclk,
    input  logic          rst_lck,
    input  logic [CW-1:0] xpos,
    input  logic [CW-1:0] ypos,
    input  logic          cursor_en,
    input  logic [CW-1:0] hcount_in,
    input  logic          hsync_in,
    input  logic          hblnk_in,
    input  logic [CW-1:0] vcount_in,
    input  logic          vsync_in,
    input  logic          vblnk_in,
    input  logic [11:0]   rgb_in,
    output logic [CW-1:0] hcount_out,
    output logic          hsync_out,
    output logic          hblnk_out,
    output logic [CW-1:0] vcount_out,
    output logic          vsync_out,
    output logic          vblnk_out,
    output logic [11:0]   rgb_out
);

    localparam int unsigned DW   = CW + 1;
    localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0]   X_MAX   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0]   Y_MAX   = CW'(V_ACTIVE - 1);
    localparam logic [DW-1:0]   BOX_W   = DW'(CUR_W);
    localparam logic [DW-1:0]   BOX_H   = DW'(CUR_H);
    localparam logic [DW-1:0]   LAST_DY = DW'(CUR_H - 1);
    localparam logic [FC_W-1:0] FC_LAST = (BLINK_FRAMES == 0) ? '0 : FC_W'(BLINK_FRAMES - 1);

    // Frame-start shadow state
    logic            vblnk_d_q;
    logic [CW-1:0]   x_act_q, x_act_d;
    logic [CW-1:0]   y_act_q, y_act_d;
    logic            en_act_q, en_act_d;
    logic            vis_q, vis_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            fe_c;

    // Stage 1
    logic [CW-1:0] s1_hcount_q, s1_vcount_q;
    logic          s1_hsync_q, s1_hblnk_q, s1_vsync_q, s1_vblnk_q;
    logic [11:0]   s1_rgb_q;
    logic          s1_in_box_q, s1_in_box_d;
    logic          s1_border_q, s1_border_d;
    logic          s1_blank_q, s1_blank_d;
    logic [DW-1:0] dx_c, dy_c;

    // Stage 2
    logic [CW-1:0] s2_hcount_q, s2_vcount_q;
    logic          s2_hsync_q, s2_hblnk_q, s2_vsync_q, s2_vblnk_q;
    logic [11:0]   s2_rgb_q, s2_rgb_d;

    assign fe_c = vblnk_in & ~vblnk_d_q;

    // Latch clamped position, enable and blink phase once per frame
    always_comb begin
        x_act_d     = x_act_q;
        y_act_d     = y_act_q;
        en_act_d    = en_act_q;
        vis_d       = vis_q;
        frame_cnt_d = frame_cnt_q;
        if (fe_c) begin
            x_act_d  = (xpos > X_MAX) ? X_MAX : xpos;
            y_act_d  = (ypos > Y_MAX) ? Y_MAX : ypos;
            en_act_d = cursor_en;
            if (BLINK_FRAMES != 0) begin
                if (frame_cnt_q == FC_LAST) begin
                    frame_cnt_d = '0;
                    vis_d       = ~vis_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pclk or posedge rst_lck) begin
        if (rst_lck) begin
            vblnk_d_q   <= 1'b0;
            x_act_q     <= '0;
            y_act_q     <= '0;
            en_act_q    <= 1'b0;
            vis_q       <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            vblnk_d_q   <= vblnk_in;
            x_act_q     <= x_act_d;
            y_act_q     <= y_act_d;
            en_act_q    <= en_act_d;
            vis_q       <= vis_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Arrow shape: lower-left triangle of the box, edges drawn as border.
    // The >= guards keep the unsigned differences from matching left/above the tip.
    always_comb begin
        dx_c        = DW'(hcount_in) - DW'(x_act_q);
        dy_c        = DW'(vcount_in) - DW'(y_act_q);
        s1_in_box_d = (hcount_in >= x_act_q) && (vcount_in >= y_act_q) &&
                      (dx_c < BOX_W) && (dy_c < BOX_H) && (dx_c <= dy_c);
        s1_border_d = (dx_c == '0) || (dx_c == dy_c) || (dy_c == LAST_DY);
        s1_blank_d  = hblnk_in | vblnk_in;
    end

    always_ff @(posedge pclk or posedge rst_lck) begin
        if (rst_lck) begin
            s1_hcount_q <= '0;
            s1_vcount_q <= '0;
            s1_hsync_q  <= 1'b0;
            s1_hblnk_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_vblnk_q  <= 1'b0;
            s1_rgb_q    <= '0;
            s1_in_box_q <= 1'b0;
            s1_border_q <= 1'b0;
            s1_blank_q  <= 1'b0;
        end else begin
            s1_hcount_q <= hcount_in;
            s1_vcount_q <= vcount_in;
            s1_hsync_q  <= hsync_in;
            s1_hblnk_q  <= hblnk_in;
            s1_vsync_q  <= vsync_in;
            s1_vblnk_q  <= vblnk_in;
            s1_rgb_q    <= rgb_in;
            s1_in_box_q <= s1_in_box_d;
            s1_border_q <= s1_border_d;
            s1_blank_q  <= s1_blank_d;
        end
    end

    // Blanking overrides everything, then cursor, then pass-through
    always_comb begin
        s2_rgb_d = s1_rgb_q;
        if (s1_blank_q) begin
            s2_rgb_d = 12'h000;
        end else if (s1_in_box_q && en_act_q && vis_q) begin
            s2_rgb_d = s1_border_q ? BORDER_RGB : CUR_RGB;
        end
    end

    always_ff @(posedge pclk or posedge rst_lck) begin
        if (rst_lck) begin
            s2_hcount_q <= '0;
            s2_vcount_q <= '0;
            s2_hsync_q  <= 1'b0;
            s2_hblnk_q  <= 1'b0;
            s2_vsync_q  <= 1'b0;
            s2_vblnk_q  <= 1'b0;
            s2_rgb_q    <= '0;
        end else begin
            s2_hcount_q <= s1_hcount_q;
            s2_vcount_q <= s1_vcount_q;
            s2_hsync_q  <= s1_hsync_q;
            s2_hblnk_q  <= s1_hblnk_q;
            s2_vsync_q  <= s1_vsync_q;
            s2_vblnk_q  <= s1_vblnk_q;
            s2_rgb_q    <= s2_rgb_d;
        end
    end

    assign hcount_out = s2_hcount_q;
    assign vcount_out = s2_vcount_q;
    assign hsync_out  = s2_hsync_q;
    assign hblnk_out  = s2_hblnk_q;
    assign vsync_out  = s2_vsync_q;
    assign vblnk_out  = s2_vblnk_q;
    assign rgb_out    = s2_rgb_q;

endmodule

// File: tb/tb_cursor_overlay_pipe.sv
// Directed bench for cursor_overlay_pipe: default instance plus a BLINK_FRAMES=2 instance.
module tb_cursor_overlay_pipe;

    logic        pclk = 1'b0;
    logic        rst_lck;
    logic [11:0] xpos, ypos;
    logic        cursor_en;
    logic [11:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in;

    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] hcount_b, vcount_b, rgb_b;
    logic        hsync_b, hblnk_b, vsync_b, vblnk_b;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] s_h   [16];
    logic        s_hb  [16];
    logic [11:0] s_rgb [16];
    logic [11:0] s_exp [16];
    logic [11:0] t6_exp [12] = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000,
                                 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'hABC};

    always #5 pclk = ~pclk;

    cursor_overlay_pipe dut (
        .pclk(pclk), .rst_lck(rst_lck), .xpos(xpos), .ypos(ypos), .cursor_en(cursor_en),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    cursor_overlay_pipe #(.BLINK_FRAMES(2)) dut_b (
        .pclk(pclk), .rst_lck(rst_lck), .xpos(xpos), .ypos(ypos), .cursor_en(cursor_en),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_b), .hsync_out(hsync_b), .hblnk_out(hblnk_b),
        .vcount_out(vcount_b), .vsync_out(vsync_b), .vblnk_out(vblnk_b),
        .rgb_out(rgb_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic hb,
                         input logic vb, input logic hs, input logic vs, input logic [11:0] rgb);
        @(negedge pclk);
        hcount_in = h;
        vcount_in = v;
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = hs;
        vsync_in  = vs;
        rgb_in    = rgb;
    endtask

    // Present one visible pixel and wait for it to reach the outputs
    task automatic probe(input logic [11:0] h, input logic [11:0] v, input logic [11:0] rgb);
        drive(h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb);
        @(posedge pclk);
        @(posedge pclk);
        #1;
    endtask

    task automatic frame_edge(input logic [11:0] x, input logic [11:0] y, input logic en);
        @(negedge pclk);
        xpos      = x;
        ypos      = y;
        cursor_en = en;
        drive(12'd0, 12'd768, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
        repeat (2) @(posedge pclk);
        drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        @(posedge pclk);
    endtask

    // Stream s_* vectors one per clock; outputs must equal the vector from two edges back
    task automatic stream(input int n, input logic [11:0] v);
        int j;
        for (int k = 0; k <= n; k++) begin
            if (k < n) drive(s_h[k], v, s_hb[k], 1'b0, k[1], k[2], s_rgb[k]);
            else       drive(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
            @(posedge pclk);
            #1;
            if (k >= 1) begin
                j = k - 1;
                chk("stream_hcount", 32'(hcount_out), 32'(s_h[j]));
                chk("stream_vcount", 32'(vcount_out), 32'(v));
                chk("stream_hsync", 32'(hsync_out), 32'(j[1]));
                chk("stream_vsync", 32'(vsync_out), 32'(j[2]));
                chk("stream_hblnk", 32'(hblnk_out), 32'(s_hb[j]));
                chk("stream_vblnk", 32'(vblnk_out), 32'd0);
                chk("stream_rgb", 32'(rgb_out), 32'(s_exp[j]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_lck = 1'b1;
        xpos = '0; ypos = '0; cursor_en = 1'b0;
        hcount_in = '0; vcount_in = '0; rgb_in = '0;
        hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        rst_lck = 1'b0;

        // T1: async reset mid-frame, then pass-through tracking
        drive(12'd500, 12'd20, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF);
        repeat (3) @(posedge pclk);
        #1;
        chk("pre_rst_hcount", 32'(hcount_out), 32'd500);
        #2;
        rst_lck = 1'b1;
        #1;
        chk("rst_hcount", 32'(hcount_out), 32'd0);
        chk("rst_vcount", 32'(vcount_out), 32'd0);
        chk("rst_rgb", 32'(rgb_out), 32'd0);
        chk("rst_ctl", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'd0);
        chk("rst_rgb_b", 32'(rgb_b), 32'd0);
        @(negedge pclk);
        rst_lck = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_h[i]   = 12'(10 + i);
            s_hb[i]  = 1'b0;
            s_rgb[i] = 12'(i * 17 + 1);
            s_exp[i] = s_rgb[i];
        end
        stream(8, 12'd5);

        // T2: shape at (100,50)
        frame_edge(12'd100, 12'd50, 1'b1);
        probe(12'd100, 12'd50, 12'h123); chk("t2_tip", 32'(rgb_out), 32'h000);
        probe(12'd100, 12'd60, 12'h123); chk("t2_left_edge", 32'(rgb_out), 32'h000);
        probe(12'd105, 12'd60, 12'h123); chk("t2_fill", 32'(rgb_out), 32'hFFF);
        probe(12'd110, 12'd60, 12'h123); chk("t2_diag", 32'(rgb_out), 32'h000);
        probe(12'd111, 12'd60, 12'h123); chk("t2_dx_gt_dy", 32'(rgb_out), 32'h123);
        probe(12'd99, 12'd50, 12'h123);  chk("t2_left_of_tip", 32'(rgb_out), 32'h123);
        probe(12'd105, 12'd65, 12'h123); chk("t2_bottom_row", 32'(rgb_out), 32'h000);
        probe(12'd105, 12'd66, 12'h123); chk("t2_below_box", 32'(rgb_out), 32'h123);

        // T6: blanking over a cursor pixel plus timing alignment
        for (int i = 0; i < 12; i++) begin
            s_h[i]   = 12'(100 + i);
            s_hb[i]  = (i == 5);
            s_rgb[i] = 12'hABC;
            s_exp[i] = t6_exp[i];
        end
        stream(12, 12'd60);

        // T3: clamping
        frame_edge(12'd2000, 12'd900, 1'b1);
        probe(12'd1023, 12'd767, 12'h123); chk("t3_clamped_tip", 32'(rgb_out), 32'h000);
        probe(12'd1022, 12'd767, 12'h123); chk("t3_left_of_clamp", 32'(rgb_out), 32'h123);

        // T4: shadowing of mid-frame position changes
        frame_edge(12'd100, 12'd50, 1'b1);
        @(negedge pclk);
        xpos = 12'd300;
        probe(12'd100, 12'd50, 12'h123); chk("t4_old_pos_kept", 32'(rgb_out), 32'h000);
        probe(12'd300, 12'd50, 12'h123); chk("t4_new_pos_early", 32'(rgb_out), 32'h123);
        frame_edge(12'd300, 12'd50, 1'b1);
        probe(12'd300, 12'd50, 12'h123); chk("t4_new_pos", 32'(rgb_out), 32'h000);
        probe(12'd100, 12'd50, 12'h123); chk("t4_old_pos_gone", 32'(rgb_out), 32'h123);

        // T5: blink with BLINK_FRAMES=2 from a fresh reset
        @(negedge pclk);
        rst_lck = 1'b1;
        @(negedge pclk);
        rst_lck = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            frame_edge(12'd100, 12'd50, 1'b1);
            probe(12'd105, 12'd60, 12'h123);
            chk("t5_steady", 32'(rgb_out), 32'hFFF);
            chk("t5_blink", 32'(rgb_b), (f == 2 || f == 3) ? 32'h123 : 32'hFFF);
        end
        frame_edge(12'd100, 12'd50, 1'b0);
        probe(12'd105, 12'd60, 12'h123);
        chk("t5_disabled", 32'(rgb_out), 32'h123);
        chk("t5_disabled_b", 32'(rgb_b), 32'h123);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
